// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_op_sequencer : valid/ready front end for the shared 16-bit ALU with an
//                    internal 16-cycle restoring divider.   Rev 1.0
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int          DATA_W    = 16,
  parameter logic [3:0]  FUNC_DIV  = 4'b1000,
  parameter logic [3:0]  FUNC_IDLE = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_func_i,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  input  logic              req_cin_i,
  output logic [3:0]        alu_func_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic              alu_cin_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_c_i,
  input  logic              alu_z_i,
  input  logic              alu_v_i,
  input  logic              alu_s_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [3:0]        rsp_flags_o,
  output logic              busy_o,
  output logic              div_by_zero_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DIV   = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        alu_func_q, alu_func_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_cin_q, alu_cin_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              dbz_q, dbz_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_rem_nx;
  logic [DATA_W-1:0] w_quo_nx;
  logic              w_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_func_q  <= FUNC_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 4'b0000;
      dbz_q       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      alu_func_q  <= alu_func_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      dbz_q       <= dbz_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
    end
  end

  // One restoring-divide step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    w_rem_sh = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    w_take   = (w_rem_sh >= {1'b0, dvsr_q});
    w_rem_nx = w_take ? (w_rem_sh - {1'b0, dvsr_q}) : w_rem_sh;
    w_quo_nx = {quo_q[DATA_W-2:0], w_take};
  end

  always_comb begin
    state_d     = state_q;
    alu_func_d  = alu_func_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    dbz_d       = dbz_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          dbz_d = 1'b0;
          if (req_func_i == FUNC_DIV) begin
            dvsr_d  = req_a_i;
            quo_d   = req_b_i;
            rem_d   = '0;
            // A zero divisor runs a single DIV cycle so it responds at T+2.
            cnt_d   = (req_a_i == '0) ? 4'd15 : 4'd0;
            state_d = DIV;
          end else begin
            alu_func_d = req_func_i;
            alu_a_d    = req_a_i;
            alu_b_d    = req_b_i;
            alu_cin_d  = req_cin_i;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        rsp_data_d  = alu_out_i;
        rsp_flags_d = {alu_c_i, alu_z_i, alu_v_i, alu_s_i};
        alu_func_d  = FUNC_IDLE;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_cin_d   = 1'b0;
        state_d     = RESP;
      end
      DIV: begin
        rem_d = w_rem_nx;
        quo_d = w_quo_nx;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = RESP;
          if (dvsr_q == '0) begin
            rsp_data_d  = '1;
            rsp_flags_d = 4'b0011;
            dbz_d       = 1'b1;
          end else begin
            rsp_data_d  = w_quo_nx;
            rsp_flags_d = {1'b0, (w_quo_nx == '0), 1'b0, w_quo_nx[DATA_W-1]};
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign busy_o        = (state_q != IDLE);
  assign alu_func_o    = alu_func_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_cin_o     = alu_cin_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_flags_o   = rsp_flags_q;
  assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer : table-driven bench with a small ALU model.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_func = 4'h0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        req_cin = 1'b0;
  logic [3:0]  alu_func;
  logic [15:0] alu_a, alu_b;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_c, alu_z, alu_v, alu_s;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        busy;
  logic        div_by_zero;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_func_i(req_func),
    .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin),
    .alu_func_o(alu_func), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
    .alu_out_i(alu_out), .alu_c_i(alu_c), .alu_z_i(alu_z), .alu_v_i(alu_v), .alu_s_i(alu_s),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_flags_o(rsp_flags), .busy_o(busy), .div_by_zero_o(div_by_zero)
  );

  // Minimal ALU: 0 add, 1 sub (b-a, c=borrow), 2 and, 9 mul low; else 0.
  logic [16:0] t17;
  logic [31:0] p32;
  always_comb begin
    t17 = '0;
    p32 = '0;
    alu_out = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_func)
      4'h0: begin
        t17 = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, alu_cin};
        alu_out = t17[15:0];
        alu_c = t17[16];
        alu_v = (alu_a[15] == alu_b[15]) && (t17[15] != alu_a[15]);
      end
      4'h1: begin
        t17 = {1'b0, alu_b} - {1'b0, alu_a} - {16'b0, alu_cin};
        alu_out = t17[15:0];
        alu_c = t17[16];
        alu_v = (alu_a[15] != alu_b[15]) && (t17[15] != alu_b[15]);
      end
      4'h2: alu_out = alu_a & alu_b;
      4'h9: begin
        p32 = {16'b0, alu_a} * {16'b0, alu_b};
        alu_out = p32[15:0];
      end
      default: alu_out = '0;
    endcase
    alu_z = (alu_out == 16'h0000);
    alu_s = alu_out[15];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // Drive one request at a negedge; return cycles from accept to rsp_valid (-1 on timeout).
  task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, output int lat);
    int t0;
    @(negedge clk);
    req_func = f; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] data;
    logic [3:0]  flags;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    logic [15:0] hold_d;
    logic [3:0]  hold_f;
    logic        ok;

    //          func   a         b         cin   data      {czvs}   dbz  lat
    vecs[0]  = '{4'h0, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 4'b1100, 1'b0, 2};
    vecs[1]  = '{4'h0, 16'h0001, 16'h7FFF, 1'b0, 16'h8000, 4'b0011, 1'b0, 2};
    vecs[2]  = '{4'h0, 16'h0001, 16'h0001, 1'b1, 16'h0003, 4'b0000, 1'b0, 2};
    vecs[3]  = '{4'h1, 16'h0003, 16'h0005, 1'b0, 16'h0002, 4'b0000, 1'b0, 2};
    vecs[4]  = '{4'h1, 16'h0005, 16'h0003, 1'b0, 16'hFFFE, 4'b1001, 1'b0, 2};
    vecs[5]  = '{4'h2, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 4'b0000, 1'b0, 2};
    vecs[6]  = '{4'h9, 16'h0012, 16'h0034, 1'b0, 16'h03A8, 4'b0000, 1'b0, 2};
    vecs[7]  = '{4'hC, 16'h1234, 16'h5678, 1'b0, 16'h0000, 4'b0100, 1'b0, 2};
    vecs[8]  = '{4'hF, 16'h1111, 16'h2222, 1'b1, 16'h0000, 4'b0100, 1'b0, 2};
    vecs[9]  = '{4'h8, 16'h0007, 16'd100,  1'b0, 16'h000E, 4'b0000, 1'b0, 17};
    vecs[10] = '{4'h8, 16'h0000, 16'd1234, 1'b0, 16'hFFFF, 4'b0011, 1'b1, 2};
    vecs[11] = '{4'h8, 16'h0003, 16'h0002, 1'b0, 16'h0000, 4'b0100, 1'b0, 17};
    vecs[12] = '{4'h8, 16'h0001, 16'hFFFF, 1'b0, 16'hFFFF, 4'b0001, 1'b0, 17};
    vecs[13] = '{4'h8, 16'h0010, 16'h8000, 1'b0, 16'h0800, 4'b0000, 1'b0, 17};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_valid_busy", {29'b0, req_ready, rsp_valid, busy}, 32'b100);
    check("reset_rsp", {12'b0, rsp_flags, rsp_data}, 32'h0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'h0);
    check("reset_alu", {alu_cin, alu_func, alu_a, alu_b[10:0]}, {1'b0, 4'hF, 27'h0});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("v%0d_data", i), {16'b0, rsp_data}, {16'b0, vecs[i].data});
      check($sformatf("v%0d_flags", i), {28'b0, rsp_flags}, {28'b0, vecs[i].flags});
      check($sformatf("v%0d_dbz", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dbz});
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      finish_rsp();
    end

    // ALU drive during ISSUE and idle drive throughout DIV.
    @(negedge clk);
    req_func = 4'h0; req_a = 16'h1357; req_b = 16'h2468; req_cin = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("issue_alu_drive", {alu_cin, alu_func, alu_a, alu_b[10:0]},
          {1'b1, 4'h0, 16'h1357, 11'h468});
    @(negedge clk);
    check("issue_alu_idle_in_resp", {alu_cin, alu_func, alu_a | alu_b}, {1'b0, 4'hF, 16'h0});
    finish_rsp();

    @(negedge clk);
    req_func = 4'h8; req_a = 16'hFFFF; req_b = 16'hFFFE; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (alu_func !== 4'hF || alu_a !== 16'h0 || alu_b !== 16'h0 || rsp_valid !== 1'b0 ||
          busy !== 1'b1 || req_ready !== 1'b0) ok = 1'b0;
    end
    check("div_alu_idle_16cyc", {31'b0, ok}, 32'h1);
    @(negedge clk);
    check("div_ffff_valid_t17", {31'b0, rsp_valid}, 32'h1);
    check("div_ffff_result", {12'b0, rsp_flags, rsp_data}, {12'b0, 4'b0100, 16'h0000});
    finish_rsp();

    // Backpressure: response held 5 cycles while a competing request is ignored.
    rsp_ready = 1'b0;
    send(4'h0, 16'h0002, 16'h0003, 1'b0, lat);
    check("bp_latency", lat, 2);
    hold_d = rsp_data; hold_f = rsp_flags;
    req_func = 4'h1; req_a = 16'hAAAA; req_b = 16'h0001; req_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== hold_d ||
          rsp_flags !== hold_f) ok = 1'b0;
    end
    check("bp_stable_5cyc", {31'b0, ok}, 32'h1);
    check("bp_data", {12'b0, rsp_flags, rsp_data}, {12'b0, 4'b0000, 16'h0005});
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_released", {30'b0, rsp_valid, req_ready}, 32'b01);

    // Reset mid-divide aborts the op.
    @(negedge clk);
    req_func = 4'h8; req_a = 16'h0007; req_b = 16'd100; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {req_ready, rsp_valid, busy, div_by_zero, alu_cin, alu_func, rsp_flags},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0});
    check("rst_mid_data", {rsp_data, alu_a | alu_b}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("rst_no_response", {31'b0, ok}, 32'h1);
    send(4'h8, 16'h0007, 16'd100, 1'b0, lat);
    check("post_rst_div_lat", lat, 17);
    check("post_rst_div_data", {12'b0, rsp_flags, rsp_data}, {12'b0, 4'b0000, 16'h000E});
    finish_rsp();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
